// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares one register-file write port between pipeline (A) and long-latency (B) writebacks, with a pending-write scoreboard
module regfile_wb_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_addr,
  output logic        iss_ready,
  input  logic [4:0]  q_ra1,
  input  logic [4:0]  q_ra2,
  output logic        busy1,
  output logic        busy2,
  output logic        writeReg,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  output logic [5:0]  pend_cnt
);
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0] sb_q, sb_d;
  logic        write_reg_q, write_reg_d;
  logic [4:0]  wa_q, wa_d;
  logic [31:0] wd_q, wd_d;
  logic [5:0]  pend_cnt_q, pend_cnt_d;
  logic        starve, a_acc, b_acc, iss_acc;
  assign starve    = starve_cnt_q == 4'(STARVE_LIMIT);
  assign a_ready   = ~(b_valid & starve);
  assign b_ready   = ~a_valid | starve;
  assign iss_ready = ~sb_q[iss_addr];
  assign a_acc     = a_valid & a_ready;
  assign b_acc     = b_valid & b_ready;
  assign iss_acc   = iss_valid & iss_ready;
  assign busy1     = sb_q[q_ra1];
  assign busy2     = sb_q[q_ra2];
  assign writeReg  = write_reg_q;
  assign wa        = wa_q;
  assign wd        = wd_q;
  assign pend_cnt  = pend_cnt_q;
  // Next state: starvation counter, write-port stage, scoreboard (issue set beats B clear) and its popcount
  always_comb begin
    starve_cnt_d = (b_acc | ~b_valid) ? 4'd0 : starve ? starve_cnt_q : starve_cnt_q + 4'd1;
    write_reg_d  = a_acc ? (a_addr != 5'd0) : b_acc ? (b_addr != 5'd0) : 1'b0;
    wa_d         = a_acc ? a_addr : b_acc ? b_addr : wa_q;
    wd_d         = a_acc ? a_data : b_acc ? b_data : wd_q;
    sb_d         = (sb_q & ~(b_acc ? 32'd1 << b_addr : 32'd0)) | (iss_acc ? 32'd1 << iss_addr : 32'd0);
    sb_d[0]      = 1'b0;
    pend_cnt_d   = 6'd0;
    for (int i = 0; i < 32; i++) pend_cnt_d = pend_cnt_d + 6'(sb_d[i]);
  end
  // State registers; reset drops any accepted request that has not reached the write port yet
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt_q <= '0;
      sb_q         <= '0;
      write_reg_q  <= 1'b0;
      wa_q         <= '0;
      wd_q         <= '0;
      pend_cnt_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      sb_q         <= sb_d;
      write_reg_q  <= write_reg_d;
      wa_q         <= wa_d;
      wd_q         <= wd_d;
      pend_cnt_q   <= pend_cnt_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random stimulus against a behavioural model of the writeback arbiter
module tb_regfile_wb_arbiter;
  localparam int LIMIT = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0, iss_valid = 1'b0;
  logic [4:0] a_addr = '0, b_addr = '0, iss_addr = '0, q_ra1 = '0, q_ra2 = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic a_ready, b_ready, iss_ready, busy1, busy2, writeReg;
  logic [4:0] wa;
  logic [31:0] wd;
  logic [5:0] pend_cnt;
  int checks = 0;
  int failures = 0;
  bit m_pend[32];
  int m_cnt;
  logic m_we;
  logic [4:0] m_wa;
  logic [31:0] m_wd;
  logic last_a_rdy, last_b_rdy, last_i_rdy;

  regfile_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .q_ra1(q_ra1), .q_ra2(q_ra2), .busy1(busy1), .busy2(busy2),
    .writeReg(writeReg), .wa(wa), .wd(wd), .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_pend[i];
    return n;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_cnt = 0;
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"}, writeReg, 0);
    chk({tag, "_wa"}, wa, 0);
    chk({tag, "_wd"}, wd, 0);
    chk({tag, "_pc"}, pend_cnt, 0);
    chk({tag, "_b1"}, busy1, 0);
    chk({tag, "_b2"}, busy2, 0);
  endtask

  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic iv, input logic [4:0] ia, input logic [4:0] r1, input logic [4:0] r2);
    bit starve, ea, eb, ei, a_win, b_win;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    iss_valid = iv; iss_addr = ia; q_ra1 = r1; q_ra2 = r2;
    #1;
    starve = (m_cnt == LIMIT);
    ea = !(bv && starve);
    eb = !av || starve;
    ei = !m_pend[ia];
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    chk("iss_ready", iss_ready, ei);
    chk("busy1", busy1, m_pend[r1]);
    chk("busy2", busy2, m_pend[r2]);
    last_a_rdy = a_ready; last_b_rdy = b_ready; last_i_rdy = iss_ready;
    a_win = av && ea;
    b_win = bv && eb;
    if (a_win) begin
      m_we = (aa != 0); m_wa = aa; m_wd = ad;
    end else if (b_win) begin
      m_we = (ba != 0); m_wa = ba; m_wd = bd;
    end else m_we = 1'b0;
    if (b_win) m_pend[ba] = 1'b0;
    if (iv && ei && ia != 0) m_pend[ia] = 1'b1;
    if (!bv || b_win) m_cnt = 0;
    else if (m_cnt < LIMIT) m_cnt++;
    @(posedge clk);
    #1;
    chk("writeReg", writeReg, m_we);
    chk("wa", wa, m_wa);
    chk("wd", wd, m_wd);
    chk("pend_cnt", pend_cnt, m_count());
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic reset_mid(input logic [4:0] aa, input logic [31:0] ad);
    @(negedge clk);
    a_valid = 1'b1; a_addr = aa; a_data = ad;
    b_valid = 1'b0; iss_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    m_reset();
    chk_zero("rst_mid");
    @(negedge clk);
    a_valid = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    m_reset();
    #2 rst = 1'b0;
    #1 chk_zero("rst_init");
    @(negedge clk);
    rst = 1'b1;
    // A alone, first cycle after release
    step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    chk("a_only_rdy", last_a_rdy, 1);
    chk("a_only_wd", wd, 32'hDEADBEEF);
    chk("a_only_wa", wa, 5);
    idle();
    chk("no_acc_we", writeReg, 0);
    // Contention: A wins three times, then B once, then A again
    for (int i = 0; i < 5; i++) begin
      step(1, 5'd3, 32'h100 + i, 1, 5'd4, 32'h200 + i, 0, 0, 0, 0);
      chk($sformatf("cont_a_rdy%0d", i), last_a_rdy, i != 3);
      chk($sformatf("cont_wa%0d", i), wa, (i == 3) ? 4 : 3);
    end
    // Scoreboard: issue 7, B writes 7, re-issue while busy refused
    step(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0);
    step(0, 0, 0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0);
    chk("sb_reissue_rdy", last_i_rdy, 0);
    chk("sb_pc1", pend_cnt, 1);
    step(0, 0, 0, 1, 5'd7, 32'h77, 0, 0, 5'd7, 5'd0);
    chk("sb_pc0", pend_cnt, 0);
    idle();
    chk("sb_busy_clr", busy1, 0);
    // Same-cycle issue and B clear on 9: set wins
    step(0, 0, 0, 0, 0, 0, 1, 5'd9, 5'd9, 5'd9);
    step(0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 5'd9, 5'd9);
    step(0, 0, 0, 1, 5'd9, 32'h9A, 1, 5'd9, 5'd9, 5'd9);
    chk("same_iss_rdy", last_i_rdy, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 5'd9, 5'd9);
    chk("same_busy", busy1, 1);
    chk("same_pc", pend_cnt, 1);
    // Address 0 writes and issues are inert
    step(1, 5'd0, 32'h1234, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    chk("a0_rdy", last_a_rdy, 1);
    chk("a0_we", writeReg, 0);
    idle();
    chk("a0_busy", busy1, 0);
    // Reset with bits 8..11 pending and an A request in flight
    step(0, 0, 0, 1, 5'd9, 32'h5, 1, 5'd8, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 5'd10, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 5'd11, 5'd8, 5'd11);
    chk("pre_rst_pc", pend_cnt, 4);
    reset_mid(5'd6, 32'hCAFEF00D);
    idle();
    chk("post_rst_we", writeReg, 0);
    // Random traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) reset_mid(5'($urandom_range(0, 31)), $urandom);
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
